// File: rtl/byte_mem_ctrl_pkg.sv
// Shared types and helpers for the byte-addressed scratch memory controller.
// No logic; nothing here has latency.
// No flow control here.
package byte_mem_ctrl_pkg;

  // Controller has only two phases: zero-fill after reset, then serving requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_t;

  // Number of byte lanes in an access word.
  function automatic int unsigned word_bytes(input int unsigned word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/byte_mem_clear_fsm.sv
// Post-reset fill sequencer: walks every byte address once, then opens the request port.
// One byte per cycle; the fill takes exactly DEPTH cycles after reset is released.
// Holds ready low for the whole fill; requests cannot stall or shorten it.
module byte_mem_clear_fsm
  import byte_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = 2048,
  parameter bit          CLEAR_EN = 1'b1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          nrst,
  output logic          ready,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  typedef logic [AW-1:0] idx_t;

  clr_state_t state_q, state_d;
  idx_t       cnt_q, cnt_d;

  // State and fill-counter registers; reset restarts the fill from address 0.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= CLEAR_EN ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, fill counter advance and port-level outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == idx_t'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        ready = 1'b1;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/mem_map.vh
// Region base addresses within the node scratch memory.
// Byte addresses; every region is addressed big-endian through byte_mem_ctrl.
// Shared by the routing FSMs that build request addresses.
`ifndef MEM_MAP_VH
`define MEM_MAP_VH

`define MEM_FLAGS        16'h0000
`define MEM_KNOWN_SINKS  16'h0008
`define MEM_WORST_HOPS   16'h0028
`define MEM_NEIGHBOR_ID  16'h0048
`define MEM_CLUSTER_ID   16'h00C8
`define MEM_BATTERY      16'h0148
`define MEM_QVALUE       16'h01C8
`define MEM_SINK_IDS     16'h0248
`define MEM_HOP_MULT     16'h0648
`define MEM_BETTER_NEI   16'h0668
`define MEM_CNT_A        16'h0688
`define MEM_CNT_B        16'h068A
`define MEM_CNT_C        16'h068C
`define MEM_SINK_ID_CNT  16'h068E
`define MEM_RNG_SEED     16'h07FE

`endif

// File: rtl/byte_mem_ctrl.sv
// Byte-addressed big-endian scratch memory with lane write enables and range checking.
// Response (rsp_valid) one cycle after acceptance; read data registered at the accept edge.
// req_ready low only during post-reset fill; responses are never backpressured.
module byte_mem_ctrl
  import byte_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  INIT_BYTE = 8'h00,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [WORD_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [WORD_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_busy
);

  localparam int unsigned BYTES = word_bytes(WORD_W);
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef logic [AW-1:0]   idx_t;
  typedef logic [ADDR_W:0] ext_addr_t;

  logic [7:0]  mem [DEPTH];

  logic        clr_we;
  idx_t        clr_addr;
  logic        accept;
  logic        range_err;
  logic        do_wr;
  ext_addr_t   last_addr;
  idx_t        lane_idx [BYTES];
  logic [WORD_W-1:0] rd_word;

  byte_mem_clear_fsm #(
    .DEPTH    (DEPTH),
    .CLEAR_EN (CLEAR_EN),
    .AW       (AW)
  ) u_clear (
    .clock     (clock),
    .nrst      (nrst),
    .ready     (req_ready),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // A request presented in the reset cycle is dropped, not accepted.
  assign accept = nrst & req_valid & req_ready;

  // Highest byte touched, one bit wider than the address so the top of the
  // address space cannot wrap back into range.
  assign last_addr = {1'b0, req_addr} + ext_addr_t'(BYTES - 1);
  assign range_err = last_addr > ext_addr_t'(DEPTH - 1);
  assign do_wr     = accept & req_wr & ~range_err;

  // Byte address of each lane; lane 0 is the MSB at the request address.
  always_comb begin
    for (int k = 0; k < BYTES; k++) begin
      lane_idx[k] = idx_t'(req_addr) + idx_t'(k);
    end
  end

  // Gather lanes into a big-endian word.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < BYTES; k++) begin
      rd_word[WORD_W-1-8*k -: 8] = mem[lane_idx[k]];
    end
  end

  // Byte array: fill port during CLEAR, request lanes otherwise; no reset on contents.
  always_ff @(posedge clock) begin
    if (nrst && clr_we) begin
      mem[clr_addr] <= INIT_BYTE;
    end else if (do_wr) begin
      for (int k = 0; k < BYTES; k++) begin
        if (req_be[BYTES-1-k]) begin
          mem[lane_idx[k]] <= req_wdata[WORD_W-1-8*k -: 8];
        end
      end
    end
  end

  // Response register: one-cycle valid pulse, data/err held between responses.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err   <= range_err;
        rsp_rdata <= (!req_wr && !range_err) ? rd_word : '0;
      end
    end
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl: a 16-bit and a 32-bit instance share clock/reset.
// Fixed vector table plus hand sequences for fill, back-to-back, reset abort and range edges.
// Random traffic on the 16-bit port checked against a byte-array reference model.
module tb_byte_mem_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        nrst;

  logic        a_valid, a_ready, a_wr, a_rsp_valid, a_err, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic [1:0]  a_be;

  logic        b_valid, b_ready, b_wr, b_rsp_valid, b_err, b_busy;
  logic [15:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;

  byte_mem_ctrl #(.DEPTH(2048), .WORD_W(16), .ADDR_W(16), .INIT_BYTE(8'h00), .CLEAR_EN(1'b1)) dut16 (
    .clock(clock), .nrst(nrst), .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rdata), .rsp_err(a_err), .init_busy(a_busy)
  );

  byte_mem_ctrl #(.DEPTH(2048), .WORD_W(32), .ADDR_W(16), .INIT_BYTE(8'h00), .CLEAR_EN(1'b1)) dut32 (
    .clock(clock), .nrst(nrst), .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rdata), .rsp_err(b_err), .init_busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model [2048];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2048; i++) model[i] = 8'h00;
  endtask

  // Reference behaviour: a request touches bytes addr..addr+1, rejected if any falls off the top.
  task automatic model_apply(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [1:0] be, output logic [15:0] erd, output logic eerr);
    int a;
    a    = int'(addr);
    eerr = (a + 1 > 2047);
    erd  = 16'h0000;
    if (!eerr) begin
      if (wr) begin
        if (be[1]) model[a]     = wdata[15:8];
        if (be[0]) model[a + 1] = wdata[7:0];
      end else begin
        erd = {model[a], model[a + 1]};
      end
    end
  endtask

  task automatic op16(input logic v, input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [1:0] be, output logic av, output logic [15:0] ard, output logic aerr);
    a_valid = v; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    @(posedge clock); #1;
    av = a_rsp_valid; ard = a_rdata; aerr = a_err;
    a_valid = 1'b0;
  endtask

  task automatic op32(input logic wr, input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err, input string name);
    b_valid = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata; b_be = be;
    @(posedge clock); #1;
    b_valid = 1'b0;
    check({name, "_vld"}, 64'(b_rsp_valid), 64'(1'b1));
    check({name, "_rd"},  64'(b_rdata), 64'(exp_rd));
    check({name, "_err"}, 64'(b_err), 64'(exp_err));
  endtask

  // Release reset and measure the fill; a read is held on the 16-bit port to prove it is ignored.
  task automatic release_and_fill(input string name);
    int cnt;
    logic bad;
    cnt = 0;
    bad = 1'b0;
    a_valid = 1'b1; a_wr = 1'b0; a_addr = 16'h0048;
    nrst = 1'b1;
    while (a_busy === 1'b1 && cnt < 3000) begin
      @(posedge clock); #1;
      cnt++;
      if (a_busy === 1'b1 && (a_ready !== 1'b0 || a_rsp_valid !== 1'b0 || b_ready !== 1'b0)) bad = 1'b1;
    end
    a_valid = 1'b0;
    check({name, "_fill_cycles"}, 64'(cnt), 64'(2048));
    check({name, "_no_accept_in_fill"}, 64'(bad), 64'(1'b0));
    check({name, "_ready16"}, 64'(a_ready), 64'(1'b1));
    check({name, "_busy32"}, 64'(b_busy), 64'(1'b0));
    model_clear();
  endtask

  initial begin
    logic        av, aerr, eerr;
    logic [15:0] ard, erd, addr;
    logic        v, wr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          r;

    tbl[0]  = '{1'b1, 16'h0668, 16'h0023, 2'b11, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 16'h0668, 16'h0000, 2'b00, 16'h0023, 1'b0};
    tbl[2]  = '{1'b1, 16'h0008, 16'h1234, 2'b11, 16'h0000, 1'b0};
    tbl[3]  = '{1'b1, 16'h0008, 16'hABCD, 2'b01, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 16'h0008, 16'h0000, 2'b00, 16'h12CD, 1'b0};
    tbl[5]  = '{1'b1, 16'h0008, 16'hFFFF, 2'b00, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 16'h0008, 16'h0000, 2'b00, 16'h12CD, 1'b0};
    tbl[7]  = '{1'b0, 16'h07FE, 16'h0000, 2'b00, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 16'h07FF, 16'h0000, 2'b00, 16'h0000, 1'b1};
    tbl[9]  = '{1'b1, 16'h07FF, 16'h5555, 2'b11, 16'h0000, 1'b1};
    tbl[10] = '{1'b1, 16'h07FE, 16'hBEEF, 2'b10, 16'h0000, 1'b0};
    tbl[11] = '{1'b0, 16'h07FE, 16'h0000, 2'b00, 16'hBE00, 1'b0};
    tbl[12] = '{1'b0, 16'h0669, 16'h0000, 2'b00, 16'h2300, 1'b0};

    nrst = 1'b0;
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(a_busy), 64'(1'b1));
    check("rst_ready", 64'(a_ready), 64'(1'b0));
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'(1'b0));
    check("rst_rdata", 64'(a_rdata), 64'(16'h0000));
    check("rst_err", 64'(a_err), 64'(1'b0));

    release_and_fill("boot");

    // Filled memory reads back INIT_BYTE at the seed location.
    op16(1'b1, 1'b0, 16'h07FE, 16'h0000, 2'b00, av, ard, aerr);
    check("seed_vld", 64'(av), 64'(1'b1));
    check("seed_rd", 64'(ard), 64'(16'h0000));

    // 32-bit range edges at the top of memory.
    op32(1'b0, 16'h07FE, 32'h0,        4'b0000, 32'h0,        1'b1, "w32_rd7fe");
    op32(1'b1, 16'h07FE, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b1, "w32_wr7fe");
    op32(1'b0, 16'h07FC, 32'h0,        4'b0000, 32'h00000000, 1'b0, "w32_rd7fc_a");
    op32(1'b1, 16'h07FC, 32'h01020304, 4'b1111, 32'h0,        1'b0, "w32_wr7fc");
    op32(1'b0, 16'h07FC, 32'h0,        4'b0000, 32'h01020304, 1'b0, "w32_rd7fc_b");
    op32(1'b0, 16'h07FD, 32'h0,        4'b0000, 32'h0,        1'b1, "w32_rd7fd");
    op32(1'b1, 16'h07FC, 32'hAABBCCDD, 4'b0110, 32'h0,        1'b0, "w32_wrmid");
    op32(1'b0, 16'h07FC, 32'h0,        4'b0000, 32'h01BBCCDD & 32'hFFFFFF00 | 32'h04, 1'b0, "w32_rd7fc_c");

    // Vector table, applied back-to-back.
    for (int i = 0; i < 13; i++) begin
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, erd, eerr);
      op16(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, av, ard, aerr);
      check($sformatf("tbl%0d_vld", i), 64'(av), 64'(1'b1));
      check($sformatf("tbl%0d_rd", i), 64'(ard), 64'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d_err", i), 64'(aerr), 64'(tbl[i].exp_err));
    end

    // Back-to-back reads of a region: three consecutive pulses in order, then hold.
    op16(1'b1, 1'b1, 16'h0048, 16'h1111, 2'b11, av, ard, aerr);
    op16(1'b1, 1'b1, 16'h004A, 16'h2222, 2'b11, av, ard, aerr);
    op16(1'b1, 1'b1, 16'h004C, 16'h3333, 2'b11, av, ard, aerr);
    for (int i = 0; i < 3; i++) begin
      model_apply(1'b1, 16'(16'h0048 + 2 * i), 16'(16'h1111 * (i + 1)), 2'b11, erd, eerr);
    end
    for (int i = 0; i < 3; i++) begin
      op16(1'b1, 1'b0, 16'(16'h0048 + 2 * i), 16'h0000, 2'b00, av, ard, aerr);
      check($sformatf("b2b%0d_vld", i), 64'(av), 64'(1'b1));
      check($sformatf("b2b%0d_rd", i), 64'(ard), 64'(16'h1111 * (i + 1)));
    end
    op16(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, av, ard, aerr);
    check("hold_vld", 64'(av), 64'(1'b0));
    check("hold_rd", 64'(ard), 64'(16'h3333));
    check("hold_err", 64'(aerr), 64'(1'b0));

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 4) != 0);
      wr = 1'($urandom_range(0, 1));
      be = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      r  = int'($urandom_range(0, 9));
      if (r < 2)       addr = 16'(16'h07F0 + $urandom_range(0, 15));
      else if (r == 2) addr = 16'($urandom_range(0, 65535));
      else if (r < 6)  addr = 16'($urandom_range(0, 31));
      else             addr = 16'($urandom_range(0, 2047));
      erd = 16'h0000; eerr = 1'b0;
      if (v) model_apply(wr, addr, wdata, be, erd, eerr);
      op16(v, wr, addr, wdata, be, av, ard, aerr);
      check($sformatf("rnd%0d_vld", i), 64'(av), 64'(v));
      if (v) begin
        check($sformatf("rnd%0d_rd", i), 64'(ard), 64'(erd));
        check($sformatf("rnd%0d_err", i), 64'(aerr), 64'(eerr));
      end
    end

    // Reset arriving together with a read: no response, fill restarts from the bottom.
    op16(1'b1, 1'b1, 16'h0668, 16'h5A5A, 2'b11, av, ard, aerr);
    a_valid = 1'b1; a_wr = 1'b0; a_addr = 16'h0668;
    nrst = 1'b0;
    @(posedge clock); #1;
    check("abort_rsp_valid", 64'(a_rsp_valid), 64'(1'b0));
    check("abort_ready", 64'(a_ready), 64'(1'b0));
    check("abort_busy", 64'(a_busy), 64'(1'b1));
    check("abort_rdata", 64'(a_rdata), 64'(16'h0000));
    a_valid = 1'b0;
    @(posedge clock); #1;
    release_and_fill("refill");
    op16(1'b1, 1'b0, 16'h0668, 16'h0000, 2'b00, av, ard, aerr);
    check("refill_rd668", 64'(ard), 64'(16'h0000));
    check("refill_vld", 64'(av), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
